// File: rtl/prefix_add_sequencer.sv
// prefix_add_sequencer: sequences one 6-bit prefix adder over WORDS chunks to form a wide adder.
// Optional macro PREFIX_SEQ_SUB_EN adds op_sub for A-B via inverted B chunks and carry-in of 1.
module prefix_adder (
    input  logic [5:0] x,
    input  logic [5:0] y,
    input  logic       c_in,
    output logic [6:0] s
);
    logic [5:0] g0, p0, g1, p1, g2, p2, g3, p3;
    logic [6:0] c;
    // Kogge-Stone prefix network: spans of 1, 2 and 4 bits
    always_comb begin
        g0 = x & y;
        p0 = x ^ y;
        g1 = g0 | (p0 & {g0[4:0], 1'b0});
        p1 = p0 & {p0[4:0], 1'b1};
        g2 = g1 | (p1 & {g1[3:0], 2'b0});
        p2 = p1 & {p1[3:0], 2'b11};
        g3 = g2 | (p2 & {g2[1:0], 4'b0});
        p3 = p2 & {p2[1:0], 4'hF};
        c  = {g3 | (p3 & {6{c_in}}), c_in};
        s  = {c[6], p0 ^ c[5:0]};
    end
endmodule

module prefix_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [6*WORDS-1:0]   a,
    input  logic [6*WORDS-1:0]   b,
    input  logic                 c_in,
`ifdef PREFIX_SEQ_SUB_EN
    input  logic                 op_sub,
`endif
    input  logic                 abort,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [6*WORDS-1:0]   sum,
    output logic                 c_out,
    output logic                 busy
);
    localparam int W  = 6 * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  a_reg, b_reg;
    logic [IW-1:0] idx;
    logic          carry, c_init, last;
    logic [5:0]    x, y;
    logic [6:0]    s;

    assign last = idx == IW'(WORDS - 1);
    assign x    = a_reg[6*idx +: 6];

`ifdef PREFIX_SEQ_SUB_EN
    logic sub_reg;
    assign y      = b_reg[6*idx +: 6] ^ {6{sub_reg}};
    assign c_init = c_in | op_sub;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            sub_reg <= 1'b0;
        else if (state == IDLE && in_valid)
            sub_reg <= op_sub;
    end
`else
    assign y      = b_reg[6*idx +: 6];
    assign c_init = c_in;
`endif

    prefix_adder u_adder (.x(x), .y(y), .c_in(carry), .s(s));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = in_valid ? RUN : IDLE;
            RUN:     state_nx = abort ? IDLE : (last ? DONE : RUN);
            DONE:    state_nx = (abort || out_ready) ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    assign in_ready  = state == IDLE;
    assign busy      = state != IDLE;
    assign out_valid = state == DONE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            c_out <= 1'b0;
        end else if (state == IDLE) begin
            if (in_valid) begin
                a_reg <= a;
                b_reg <= b;
                carry <= c_init;
                idx   <= '0;
            end
        end else if (abort) begin
            c_out <= 1'b0;
            idx   <= '0;
        end else if (state == RUN) begin
            sum[6*idx +: 6] <= s[5:0];
            carry           <= s[6];
            idx             <= last ? '0 : idx + 1'b1;
            if (last)
                c_out <= s[6];
        end
    end
endmodule

// File: tb/tb_prefix_add_sequencer.sv
// tb_prefix_add_sequencer: scoreboard bench for the WORDS=4 sequencer plus a WORDS=1 instance.
module tb_prefix_add_sequencer;
    localparam int WORDS = 4;
    localparam int W     = 6 * WORDS;

    logic         clk, rst_n;
    logic         in_valid, in_ready, c_in, abort, out_valid, out_ready, c_out, busy, op_sub;
    logic [W-1:0] a, b, sum;
    logic         in_valid1, in_ready1, out_valid1, c_out1, busy1;
    logic [5:0]   a1, b1, sum1;

    int           checks = 0, failures = 0;
    int           cyc = 0, acc_cyc = 0, prev_acc = 0, hs_cyc = 0;
    logic         ov_prev = 1'b0;
    logic [W:0]   exp_q[$];

    prefix_add_sequencer #(.WORDS(WORDS)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c_in(c_in),
`ifdef PREFIX_SEQ_SUB_EN
        .op_sub(op_sub),
`endif
        .abort(abort), .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .c_out(c_out), .busy(busy)
    );

    prefix_add_sequencer #(.WORDS(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid1), .in_ready(in_ready1),
        .a(a1), .b(b1), .c_in(1'b0),
`ifdef PREFIX_SEQ_SUB_EN
        .op_sub(1'b0),
`endif
        .abort(1'b0), .out_valid(out_valid1), .out_ready(1'b1),
        .sum(sum1), .c_out(c_out1), .busy(busy1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic sub);
        return sub ? {1'b0, x} + {1'b0, ~y} + (W+1)'(1) : {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Handshakes are judged mid-cycle, where they decide the next rising edge
    always @(negedge clk) begin
        logic [W:0] e;
        if (rst_n && in_valid && in_ready) begin
            prev_acc = acc_cyc;
            acc_cyc  = cyc;
        end
        if (out_valid && !ov_prev)
            chk("latency", 64'(cyc - acc_cyc - 1), 64'(WORDS));
        if (out_valid && out_ready) begin
            hs_cyc = cyc;
            if (exp_q.size() == 0)
                chk("unexpected_result", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("sum", 64'(sum), 64'(e[W-1:0]));
                chk("c_out", 64'(c_out), 64'(e[W]));
            end
        end
        ov_prev = out_valid;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci,
                        input logic sub, input bit push);
        int   n = 0;
        logic was;
        a = x; b = y; c_in = ci; op_sub = sub; in_valid = 1'b1;
        if (push) exp_q.push_back(model(x, y, ci, op_sub));
        do begin
            was = in_ready;
            step(1);
            n++;
        end while (!was && n < 50);
        if (!was) chk("accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            step(1);
            n++;
        end
        chk("drain", 64'(exp_q.size()), 0);
    endtask

    task automatic wait_ov();
        int n = 0;
        while (!out_valid && n < 50) begin
            step(1);
            n++;
        end
        chk("wait_valid", 64'(out_valid), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; abort = 1'b0;
        out_ready = 1'b1; op_sub = 1'b0; in_valid1 = 1'b0; a1 = '0; b1 = '0;
        #12;
        chk("rst_in_ready", 64'(in_ready), 1);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_busy", 64'(busy), 0);
        chk("rst_sum", 64'(sum), 0);
        chk("rst_c_out", 64'(c_out), 0);
        @(negedge clk) rst_n = 1'b1;
        step(1);

        // full carry ripple
        send(24'hFFFFFF, 24'h000001, 1'b0, 1'b0, 1);
        chk("run_busy", 64'(busy), 1);
        chk("run_in_ready", 64'(in_ready), 0);
        drain();
        chk("idle_in_ready", 64'(in_ready), 1);
        chk("idle_busy", 64'(busy), 0);

        // back-pressure: result held, new request refused
        out_ready = 1'b0;
        send(24'h123456, 24'h0ABCDE, 1'b1, 1'b0, 1);
        wait_ov();
        in_valid = 1'b1; a = 24'h111111; b = 24'h222222;
        repeat (5) begin
            step(1);
            chk("hold_valid", 64'(out_valid), 1);
            chk("hold_in_ready", 64'(in_ready), 0);
            chk("hold_sum", 64'(sum), 64'h1CF135);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        drain();
        chk("post_hold_in_ready", 64'(in_ready), 1);
        step(1);
        chk("stale_not_accepted", 64'(busy), 0);

        // back-to-back with in_valid held
        send(24'h00ABCD, 24'h001234, 1'b0, 1'b0, 1);
        send(24'hFFFFFF, 24'h000000, 1'b1, 1'b0, 1);
        chk("turnaround", 64'(acc_cyc - hs_cyc), 1);
        chk("period", 64'(acc_cyc - prev_acc), 6);
        drain();
        chk("carry_out_set", 64'(c_out), 1);

        // abort on the second RUN cycle
        send(24'h000FFF, 24'h000001, 1'b0, 1'b0, 0);
        step(1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort_busy", 64'(busy), 0);
        chk("abort_in_ready", 64'(in_ready), 1);
        chk("abort_out_valid", 64'(out_valid), 0);
        chk("abort_c_out", 64'(c_out), 0);
        step(6);
        chk("abort_no_result", 64'(out_valid), 0);
        send(24'h000001, 24'h000002, 1'b0, 1'b0, 1);
        drain();

        // abort while DONE, then abort ignored in IDLE
        out_ready = 1'b0;
        send(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0, 0);
        wait_ov();
        chk("done_c_out", 64'(c_out), 1);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("done_abort_valid", 64'(out_valid), 0);
        chk("done_abort_c_out", 64'(c_out), 0);
        chk("done_abort_in_ready", 64'(in_ready), 1);
        out_ready = 1'b1;
        abort = 1'b1;
        send(24'h000005, 24'h000006, 1'b0, 1'b0, 1);
        abort = 1'b0;
        drain();

        for (int i = 0; i < 12; i++) begin
            send(W'($urandom), W'($urandom), 1'($urandom), 1'b0, 1);
            for (int n = 0; n < 200 && exp_q.size() != 0; n++) begin
                out_ready = 1'($urandom);
                step(1);
            end
            out_ready = 1'b1;
            drain();
        end

        // asynchronous reset mid-RUN
        send(24'hABCDEF, 24'h111111, 1'b0, 1'b0, 0);
        step(1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_in_ready", 64'(in_ready), 1);
        chk("arst_busy", 64'(busy), 0);
        chk("arst_out_valid", 64'(out_valid), 0);
        chk("arst_sum", 64'(sum), 0);
        chk("arst_c_out", 64'(c_out), 0);
        @(negedge clk) rst_n = 1'b1;
        step(1);

        // WORDS=1 instance
        chk("w1_in_ready", 64'(in_ready1), 1);
        in_valid1 = 1'b1; a1 = 6'h3F; b1 = 6'h01;
        step(1);
        in_valid1 = 1'b0;
        chk("w1_run_valid", 64'(out_valid1), 0);
        chk("w1_run_busy", 64'(busy1), 1);
        step(1);
        chk("w1_valid", 64'(out_valid1), 1);
        chk("w1_sum", 64'(sum1), 0);
        chk("w1_c_out", 64'(c_out1), 1);
        step(1);
        chk("w1_idle_valid", 64'(out_valid1), 0);
        chk("w1_idle_ready", 64'(in_ready1), 1);

`ifdef PREFIX_SEQ_SUB_EN
        send(24'h000005, 24'h000007, 1'b0, 1'b1, 1);
        drain();
        send(24'h000007, 24'h000005, 1'b1, 1'b1, 1);
        drain();
        send(24'h000007, 24'h000005, 1'b1, 1'b0, 1);
        drain();
`endif

        step(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/prefix_add_sequencer.md
Name: prefix_add_sequencer

Overview:
Multi-cycle wide-operand adder controller built around one shared 6-bit prefix_adder datapath instance (X[5:0], Y[5:0], c_in, S[6:0]). It accepts two WORDS×6-bit operands over a valid/ready handshake and processes one 6-bit chunk per clock, LSB chunk first. The carry is chained through a register between chunks. The full sum and carry-out are presented on a valid/ready output handshake. The block sits between a requesting engine and the combinational adder, sequencing the adder to form a wide adder.

Parameters:
WORDS, 4, number of 6-bit chunks per operand; legal range 1..64; operand width W = 6*WORDS.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands and carry-in valid
in_ready  output  1  block can accept operands
a  input  W  operand A
b  input  W  operand B
c_in  input  1  carry into chunk 0
abort  input  1  synchronous cancel of the current operation
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  W  registered wide sum
c_out  output  1  registered carry out of the top chunk
busy  output  1  high whenever state != IDLE

Behaviour:
- Interface decision: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, c_out=0, chunk index=0, carry register=0, operand registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready: latch a, b, c_in (carry reg <= c_in); index <= 0; go to RUN.
  - sum and c_out keep their last values.
- RUN:
  - in_ready=0; in_valid is ignored and nothing is latched.
  - Each cycle the adder sees X=A_reg chunk[idx], Y=B_reg chunk[idx], c_in=carry reg.
  - At the clock edge: sum chunk[idx] <= S[5:0]; carry reg <= S[6]; idx <= idx+1.
  - When idx==WORDS-1: c_out <= S[6], go to DONE, idx <= 0.
- DONE:
  - out_valid=1; sum and c_out are stable.
  - On out_valid & out_ready: go to IDLE.
  - in_ready rises the following cycle; there is no same-cycle turnaround.
- Latency: out_valid rises exactly WORDS cycles after the acceptance edge. Throughput is one operation per WORDS+2 cycles when out_ready is held high.
- abort:
  - Highest priority; effective in RUN and DONE.
  - Next state is IDLE; out_valid deasserts next cycle; the partial sum may remain in the sum register; c_out is cleared to 0.
  - Ignored in IDLE, including when in_valid is high in the same cycle: the accept takes place normally.
- Index counter width is max(1, clog2(WORDS)). For WORDS=1, RUN lasts one cycle.
- rst_n asserted mid-RUN or mid-DONE returns the block to reset values immediately, with no result emitted.
- Only one prefix_adder instance is used. No combinational path exists from the inputs to out_valid, sum or c_out. in_ready and busy are decoded from state only.

Optional Feature:
Macro PREFIX_SEQ_SUB_EN.
- Defined:
  - Adds input port op_sub (1 bit), latched on acceptance.
  - When op_sub=1: each B chunk is inverted before it reaches the adder, the carry register initialises to 1 and c_in is ignored. Result is A-B mod 2^W; c_out=1 means no borrow (A>=B unsigned).
  - When op_sub=0: behaviour is identical to plain addition.
- Undefined: op_sub port and inversion logic are absent; the block only adds.

Test Plan:
- WORDS=4, a=0xFFFFFF, b=0x000001, c_in=0, out_ready=1 -> out_valid rises 4 cycles after accept; sum=0x000000, c_out=1, carry ripples through all chunks.
- WORDS=4, a=0x123456, b=0x0ABCDE, c_in=1 -> sum=0x1CF135, c_out=0. Hold out_ready=0 for 5 cycles: sum held stable, out_valid stays 1, in_ready stays 0. A new in_valid during this window is not accepted.
- Back-to-back with out_ready=1: second in_valid held high -> accepted exactly 1 cycle after the first out_valid&out_ready handshake; operation period measured as 6 cycles.
- abort pulsed at the 2nd RUN cycle of a=0x000FFF, b=0x000001 -> state IDLE next cycle, out_valid never asserts, c_out=0, in_ready=1. A following op a=1, b=2 returns sum=0x000003.
- rst_n pulsed low asynchronously mid-RUN (between clock edges) -> all outputs take reset values immediately. After release, WORDS=1 op a=0x3F, b=0x01 -> sum=0x00, c_out=1, 1 cycle latency.
- PREFIX_SEQ_SUB_EN defined, op_sub=1, a=0x000005, b=0x000007 -> sum=0xFFFFFE, c_out=0. With a=7, b=5 -> sum=0x000002, c_out=1.
